// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the 5-stage MIPS pipeline slice.
//   ifState_e          : run-control FSM states (IDLE / RUN / HALTED)
//   NOP_INSTR          : encoding used for pipeline bubbles
//   DEFAULT_HALT_INSTR : default encoding that stops fetch
//   PC_STEP            : byte increment between sequential instructions
// -----------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } ifState_e;

  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] PC_STEP            = 32'd4;

endpackage

// File: rtl/instr_memory.sv
// -----------------------------------------------------------------------------
// instr_memory
// Instruction memory of 2^ADDR_WIDTH 32-bit words.
// One synchronous write port (used by the debug loader) and one asynchronous
// read port (used by fetch).
//   clock : write clock
//   we    : write enable
//   wAddr : write word address
//   wData : write data
//   rAddr : read word address
//   rData : read data, combinational from rAddr
// -----------------------------------------------------------------------------
module instr_memory #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wAddr,
  input  logic [31:0]           wData,
  input  logic [ADDR_WIDTH-1:0] rAddr,
  output logic [31:0]           rData
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [0:DEPTH-1];

  // Loader writes land on the rising edge; no reset so contents survive a
  // pipeline reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[wAddr] <= wData;
    end
  end

  assign rData = mem[rAddr];

endmodule

// File: rtl/stage_if.sv
// -----------------------------------------------------------------------------
// stage_if
// Instruction-fetch stage. Holds the PC, reads instruction memory and
// registers instr / pc_id / nop_if towards the ID stage. A run-control FSM
// (IDLE -> RUN -> HALTED) gates fetching: the loader may fill memory only in
// IDLE, and fetching the halt word stops the machine.
//
// Ports
//   clock, reset  : clock, synchronous active-high reset
//   start         : leave IDLE and begin fetching at PC 0 (level, IDLE only)
//   stall         : hold PC and ID-facing registers
//   isJumped      : taken branch/jump, redirect to branchTarget and flush
//   branchTarget  : redirect byte address (low two bits dropped)
//   imemWe/Addr/Data : loader write port, honoured only in IDLE
//   instr         : registered instruction to ID
//   pc_id         : registered PC+4 of instr
//   nop_if        : instr is a bubble
//   running       : FSM in RUN
//   halted        : FSM in HALTED
//
// Optional feature (macro STAGE_IF_STEP_EN): adds stepMode/step inputs. With
// stepMode=1 the normal advance happens only on edges where step=1; redirects
// still take effect on any edge.
// -----------------------------------------------------------------------------
module stage_if
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  isJumped,
  input  logic [31:0]           branchTarget,
  input  logic                  imemWe,
  input  logic [ADDR_WIDTH-1:0] imemAddr,
  input  logic [31:0]           imemData,
`ifdef STAGE_IF_STEP_EN
  input  logic                  stepMode,
  input  logic                  step,
`endif
  output logic [31:0]           instr,
  output logic [31:0]           pc_id,
  output logic                  nop_if,
  output logic                  running,
  output logic                  halted
);

  ifState_e    state;
  ifState_e    stateNext;
  logic [31:0] pc;
  logic [31:0] pcNext;
  logic [31:0] instrNext;
  logic [31:0] pcIdNext;
  logic        nopNext;
  logic        memWe;
  logic [31:0] fetchWord;
  logic        advance;
  logic [1:0]  unusedTargetBits;

  // Instructions are word aligned, so the byte offset of a redirect is dropped.
  assign unusedTargetBits = branchTarget[1:0];

`ifdef STAGE_IF_STEP_EN
  assign advance = !stall && (!stepMode || step);
`else
  assign advance = !stall;
`endif

  // Word index ignores PC bits above ADDR_WIDTH+1, so addresses alias.
  instr_memory #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) imem (
    .clock (clock),
    .we    (memWe),
    .wAddr (imemAddr),
    .wData (imemData),
    .rAddr (pc[ADDR_WIDTH+1:2]),
    .rData (fetchWord)
  );

  // State, PC and ID-facing registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= 32'd0;
      instr  <= NOP_INSTR;
      pc_id  <= 32'd0;
      nop_if <= 1'b1;
    end else begin
      state  <= stateNext;
      pc     <= pcNext;
      instr  <= instrNext;
      pc_id  <= pcIdNext;
      nop_if <= nopNext;
    end
  end

  // Next-state and register updates. Within RUN, redirect beats stall beats
  // the normal advance; a fetched halt word is replaced by a bubble and the PC
  // stays on the halt address.
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    instrNext = instr;
    pcIdNext  = pc_id;
    nopNext   = nop_if;
    memWe     = 1'b0;

    unique case (state)
      IDLE: begin
        memWe     = imemWe;
        pcNext    = 32'd0;
        instrNext = NOP_INSTR;
        pcIdNext  = 32'd0;
        nopNext   = 1'b1;
        if (start) begin
          stateNext = RUN;
        end
      end

      RUN: begin
        if (isJumped) begin
          pcNext    = {branchTarget[31:2], 2'b00};
          instrNext = NOP_INSTR;
          pcIdNext  = 32'd0;
          nopNext   = 1'b1;
        end else if (advance) begin
          if (fetchWord == HALT_INSTR) begin
            instrNext = NOP_INSTR;
            pcIdNext  = 32'd0;
            nopNext   = 1'b1;
            stateNext = HALTED;
          end else begin
            instrNext = fetchWord;
            pcIdNext  = pc + PC_STEP;
            nopNext   = 1'b0;
            pcNext    = pc + PC_STEP;
          end
        end
      end

      HALTED: begin
        instrNext = NOP_INSTR;
        pcIdNext  = 32'd0;
        nopNext   = 1'b1;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign running = (state == RUN);
  assign halted  = (state == HALTED);

endmodule

// File: tb/tb_stage_if.sv
// -----------------------------------------------------------------------------
// tb_stage_if
// Directed bench for stage_if. Each cycle the driver applies one stimulus
// vector and queues the hand-computed outputs expected after the next rising
// edge; an independent monitor pops and checks them on every falling edge.
// Define STAGE_IF_STEP_EN to also exercise single-step mode.
// -----------------------------------------------------------------------------
module tb_stage_if;

  localparam int unsigned AW = 10;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        rst;
    logic        st;
    logic        stl;
    logic        jmp;
    logic [31:0] tgt;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] data;
    logic        sm;
    logic        sp;
  } stimT;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcId;
    logic        nop;
    logic        run;
    logic        halt;
  } expT;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          isJumped = 1'b0;
  logic [31:0]   branchTarget = 32'd0;
  logic          imemWe = 1'b0;
  logic [AW-1:0] imemAddr = '0;
  logic [31:0]   imemData = 32'd0;
  logic          stepMode = 1'b0;
  logic          step = 1'b0;
  logic [31:0]   instr;
  logic [31:0]   pc_id;
  logic          nop_if;
  logic          running;
  logic          halted;

  expT expQ[$];
  int  total = 0;
  int  bad = 0;

  always #5 clock = ~clock;

  stage_if #(
    .ADDR_WIDTH(AW),
    .HALT_INSTR(HALT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .isJumped     (isJumped),
    .branchTarget (branchTarget),
    .imemWe       (imemWe),
    .imemAddr     (imemAddr),
    .imemData     (imemData),
`ifdef STAGE_IF_STEP_EN
    .stepMode     (stepMode),
    .step         (step),
`endif
    .instr        (instr),
    .pc_id        (pc_id),
    .nop_if       (nop_if),
    .running      (running),
    .halted       (halted)
  );

  function automatic stimT mkS(logic rst, logic st, logic stl, logic jmp,
                               logic [31:0] tgt, logic we, logic [9:0] addr,
                               logic [31:0] data, logic sm, logic sp);
    stimT s;
    s.rst = rst; s.st = st; s.stl = stl; s.jmp = jmp; s.tgt = tgt;
    s.we = we; s.addr = addr; s.data = data; s.sm = sm; s.sp = sp;
    return s;
  endfunction

  function automatic expT mkE(logic [31:0] i, logic [31:0] p, logic n,
                              logic r, logic h);
    expT e;
    e.instr = i; e.pcId = p; e.nop = n; e.run = r; e.halt = h;
    return e;
  endfunction

  // Drive one cycle of inputs just after the falling edge and queue what the
  // outputs must look like after the following rising edge.
  task automatic applyStimulus(input stimT s, input expT e);
    @(negedge clock);
    #1;
    reset        = s.rst;
    start        = s.st;
    stall        = s.stl;
    isJumped     = s.jmp;
    branchTarget = s.tgt;
    imemWe       = s.we;
    imemAddr     = s.addr;
    imemData     = s.data;
    stepMode     = s.sm;
    step         = s.sp;
    expQ.push_back(e);
  endtask

  task automatic checkField(input string name, input logic [31:0] got,
                            input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s @%0t got=0x%08h want=0x%08h", name, $time, got, want);
    end
  endtask

  task automatic checkOutput(input expT e);
    checkField("instr",   instr,                 e.instr);
    checkField("pc_id",   pc_id,                 e.pcId);
    checkField("nop_if",  {31'd0, nop_if},       {31'd0, e.nop});
    checkField("running", {31'd0, running},      {31'd0, e.run});
    checkField("halted",  {31'd0, halted},       {31'd0, e.halt});
  endtask

  // Monitor: every falling edge, check the expectation queued for the rising
  // edge just before it.
  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  initial begin
    expT idleE;
    expT runBub;
    expT haltE;
    idleE  = mkE(32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    runBub = mkE(32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
    haltE  = mkE(32'd0, 32'd0, 1'b1, 1'b0, 1'b1);

    $display("[TB] stage_if bench start");

    // Reset, then IDLE with start low for 10 cycles while the loader fills memory.
    for (int i = 0; i < 2; i++)
      applyStimulus(mkS(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), idleE);
    applyStimulus(mkS(0, 0, 0, 0, 0, 1, 10'd0,    32'h11, 0, 0), idleE);
    applyStimulus(mkS(0, 0, 0, 0, 0, 1, 10'd1,    32'h22, 0, 0), idleE);
    applyStimulus(mkS(0, 0, 0, 0, 0, 1, 10'd2,    32'h33, 0, 0), idleE);
    applyStimulus(mkS(0, 0, 0, 0, 0, 1, 10'd3,    HALT,   0, 0), idleE);
    applyStimulus(mkS(0, 0, 0, 0, 0, 1, 10'd1023, 32'h55, 0, 0), idleE);
    for (int i = 0; i < 5; i++)
      applyStimulus(mkS(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), idleE);

    // Start, sequential fetch, 3-cycle stall, redirect under stall, halt.
    applyStimulus(mkS(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), runBub);
    applyStimulus(mkS(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mkE(32'h11, 32'd4, 0, 1, 0));
    applyStimulus(mkS(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mkE(32'h22, 32'd8, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      applyStimulus(mkS(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), mkE(32'h22, 32'd8, 0, 1, 0));
    applyStimulus(mkS(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mkE(32'h33, 32'd12, 0, 1, 0));
    applyStimulus(mkS(0, 0, 1, 1, 32'h9, 0, 0, 0, 0, 0), runBub);
    applyStimulus(mkS(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mkE(32'h33, 32'd12, 0, 1, 0));
    applyStimulus(mkS(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), haltE);
    for (int i = 0; i < 2; i++)
      applyStimulus(mkS(0, 0, 0, 0, 0, 1, 10'd0, 32'hDEADBEEF, 0, 0), haltE);
    applyStimulus(mkS(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), idleE);

    // Restart: halted-time write must not have landed; PC wrap and aliasing.
    applyStimulus(mkS(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), idleE);
    applyStimulus(mkS(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), runBub);
    applyStimulus(mkS(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mkE(32'h11, 32'd4, 0, 1, 0));
    applyStimulus(mkS(0, 0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 0), runBub);
    applyStimulus(mkS(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mkE(32'h55, 32'd0, 0, 1, 0));
    applyStimulus(mkS(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mkE(32'h11, 32'd4, 0, 1, 0));
    applyStimulus(mkS(0, 0, 0, 1, 32'h0000_1004, 0, 0, 0, 0, 0), runBub);
    applyStimulus(mkS(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mkE(32'h22, 32'h1008, 0, 1, 0));
    applyStimulus(mkS(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), mkE(32'h33, 32'h100C, 0, 1, 0));
    applyStimulus(mkS(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), haltE);

`ifdef STAGE_IF_STEP_EN
    // Single-step: three step pulses four cycles apart give three advances.
    begin
      logic [31:0] words [3];
      expT held;
      words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
      applyStimulus(mkS(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), idleE);
      applyStimulus(mkS(0, 1, 0, 0, 0, 0, 0, 0, 1, 0), runBub);
      held = runBub;
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 3; j++)
          applyStimulus(mkS(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), held);
        held = mkE(words[k], 32'(4 * (k + 1)), 1'b0, 1'b1, 1'b0);
        applyStimulus(mkS(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), held);
      end
      for (int j = 0; j < 2; j++)
        applyStimulus(mkS(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), held);
    end
`endif

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 4 && expQ.size() != 0; i++)
      @(negedge clock);
    @(negedge clock);
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain got=%0d pending want=0 pending", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout got=running want=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/stage_if.md
# stage_if

Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the program counter, reads the instruction memory and registers `instr`, `pc_id` and `nop_if` into `stage_id`. It accepts `stall` from the hazard unit and taken-branch redirects (`isJumped`, `branchTarget`) from the branch logic. A small run-control FSM gates fetching: the debug loader fills memory while idle, and a halt word stops the machine.

## Interface
- `ADDR_WIDTH`, 10: instruction memory word-address width (depth = 2^ADDR_WIDTH words).
- `HALT_INSTR`, 32'hFFFF_FFFF: encoding that halts fetch.
- `clock` in 1: clock; all state updates on the rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: leave IDLE and begin fetching at PC 0.
- `stall` in 1: hold PC and ID-facing registers.
- `isJumped` in 1: taken branch or jump; redirect and flush.
- `branchTarget` in 32: redirect address.
- `imemWe` in 1: loader write enable.
- `imemAddr` in ADDR_WIDTH: loader word address.
- `imemData` in 32: loader write data.
- `instr` out 32: registered instruction to ID.
- `pc_id` out 32: registered PC+4 of `instr`.
- `nop_if` out 1: `instr` is a bubble.
- `running` out 1: FSM in RUN.
- `halted` out 1: FSM in HALTED.

## Operation
- FSM states: IDLE → RUN on `start`. RUN → HALTED when the fetched word equals HALT_INSTR and `isJumped`=0. HALTED is left only by `reset`.
- Reset values: state IDLE, `pc`=0, `instr`=0, `pc_id`=0, `nop_if`=1, `running`=0, `halted`=0.
- IDLE:
  - Loader writes are accepted: `imem[imemAddr] <= imemData` when `imemWe`=1.
  - Outputs emit a bubble (`instr`=0, `nop_if`=1).
  - `pc` holds 0.
- RUN / HALTED: `imemWe` is ignored.
- RUN update priority is `isJumped` > `stall` > normal:
  - `isJumped`: `pc <= {branchTarget[31:2],2'b00}`; `instr` <= 0; `nop_if` <= 1; `pc_id` <= 0. This applies even when `stall`=1.
  - `stall`: all registers hold.
  - Normal: `instr <= imem[pc[ADDR_WIDTH+1:2]]`; `pc_id <= pc+4`; `nop_if <= 0`; `pc <= pc+4`.
- Halt word fetched: emit a bubble instead of the halt word, freeze `pc` at the halt address, and go to HALTED.
- HALTED: bubble outputs, `pc` frozen.
- Arithmetic: `pc` is 32-bit and wraps modulo 2^32. Memory index bits above ADDR_WIDTH+1 are ignored, so addresses alias.

## Timing
- Memory read is asynchronous (combinational from `pc`). Fetch-to-ID latency is 1 cycle: the word at `pc` appears on `instr` the edge after it is addressed.
- Redirect: `isJumped` sampled at edge N. The bubble is visible after N. The target instruction is visible after edge N+1.
- `start` is a level; it is sampled only in IDLE. The first real instruction (address 0) is visible one edge after the IDLE→RUN edge.
- A loader write at edge N is readable by a fetch issued at edge N+1 or later.
- Reset mid-RUN or in HALTED returns to the reset values on the next edge. Memory contents are preserved.

## Configuration
- `STAGE_IF_STEP_EN`
  - Defined: adds inputs `stepMode` (1 bit) and `step` (1 bit). In RUN with `stepMode`=1, the normal fetch advance happens only on edges where `step`=1. Other edges behave as `stall`, except `isJumped`, which still redirects and flushes. With `stepMode`=0, behaviour is free-running.
  - Undefined: ports absent; RUN fetches every non-stalled cycle.

## Structure
- Shared `mips_pkg`: FSM state typedef (IDLE/RUN/HALTED), `NOP_INSTR`=32'h0, default `HALT_INSTR`, `PC_STEP`=4.
- Sub-module `instr_memory`: 2^ADDR_WIDTH×32, one synchronous write port, one asynchronous read port.
- `stage_if` contains the PC register, run-control FSM and output registers.

## Test plan
- Reset → `instr`=0, `pc_id`=0, `nop_if`=1, `halted`=0, `running`=0; `start` held low keeps this for 10 cycles.
- Load words 0x11,0x22,0x33 at addresses 0..2, pulse `start` → consecutive `instr`/`pc_id` = 0x11/4, 0x22/8, 0x33/12 with `nop_if`=0.
- `stall` for 3 cycles after 0x22 → `instr`=0x22 and `pc_id`=8 held for 3 cycles, then 0x33/12.
- `isJumped`=1 with `branchTarget`=0x9 while `stall`=1 → next `nop_if`=1 and `instr`=0, then `instr`=imem[2] with `pc_id`=12.
- HALT_INSTR at address 3 → bubble on the next edge, then `halted`=1, `running`=0; `imemWe` writes ignored; reset returns to IDLE.
- With `STAGE_IF_STEP_EN`, `stepMode`=1: three `step` pulses spaced 4 cycles apart → exactly three advances of `pc_id` (4, 8, 12).
